snake_core_multi: RTL and testbench
===================================

# snake_core_multi

Second-generation snake motion core for the 640x480 VGA snake game, clocked on the pixel clock and advanced by the game-rate `tick`. Keeps a shift-register body of up to MAX_LEN pixel-aligned segments and adds several features: a selectable wall mode (clamp-with-death or wrap-around), reversal rejection, self-collision detection, multi-segment growth per food with a pending-growth counter, and an IDLE/RUN/DEAD game state machine. It feeds the renderer through packed body buses and the food/score logic through `alive`, `game_over` and `step`.

## Interface
- `CELL`, 10: cell size in pixels; every coordinate is a multiple of CELL.
- `GRID_W`, 64: grid width in cells.
- `GRID_H`, 48: grid height in cells.
- `MAX_LEN`, 32: maximum segment count, 2..255.
- `INIT_LEN`, 2: length after reset and after restart, 2..MAX_LEN.
- `GROW_PER_FOOD`, 1: segments added per `eat_evt`, 1..15.
- `WRAP_MODE`, 0: 0 = wall hit kills; 1 = head wraps to the opposite border.
- `START_X`, 310 / `START_Y`, 230: initial head pixel position.
- `clk_pix` input 1: pixel clock, the only clock.
- `reset` input 1: asynchronous, active-high reset.
- `tick` input 1: one-cycle pulse; one move step.
- `start` input 1: one-cycle pulse; starts or restarts the game.
- `dir` input 2: requested direction: 0=UP, 1=LEFT, 2=DOWN, 3=RIGHT.
- `eat_evt` input 1: one-cycle pulse; food eaten.
- `head_x` output 10 / `head_y` output 9: current head position in pixels.
- `length` output 8: live segment count.
- `alive` output 1: high while the state is RUN.
- `game_over` output 1: one-cycle pulse on entry to DEAD.
- `step` output 1: one-cycle pulse the cycle after a move is committed.
- `body_bus_x` output MAX_LEN*10: packed segment X positions, seg0 in the MSBs.
- `body_bus_y` output MAX_LEN*9: packed segment Y positions, seg0 in the MSBs.

## Operation
- Playfield limits:
  - Minimum is BX=CELL, BY=CELL.
  - Maximum is MX=(GRID_W-2)*CELL, MY=(GRID_H-2)*CELL.
- States:
  - IDLE: `start` -> RUN.
  - RUN: collision on tick -> DEAD.
  - DEAD: `start` -> reinitialise, then RUN.
  - `tick` is ignored in IDLE and DEAD.
- Initialisation (reset, or `start` in DEAD):
  - seg0 = (START_X, START_Y).
  - seg1..seg[INIT_LEN-1] placed at START_X - i*CELL, same Y.
  - Remaining segments = the tail position.
  - `length`=INIT_LEN, current direction=RIGHT, pending growth=0.
- Direction:
  - `dir` is sampled on tick.
  - If it is the exact opposite of the current direction, it is ignored and the current direction is kept.
- Next head: current head ± CELL along the effective direction.
  - WRAP_MODE=1: stepping below the minimum goes to the maximum, and stepping above the maximum goes to the minimum, per axis.
  - WRAP_MODE=0: a step past a limit is a wall collision. Positions stay unchanged and the state goes to DEAD.
- Growth:
  - pend_eff = pending + (eat_evt ? GROW_PER_FOOD : 0).
  - On a tick with pend_eff>0 and `length`<MAX_LEN: the body shifts into slot `length`, so the old tail is kept; `length`+1; pending = pend_eff-1.
  - On a tick with pend_eff>0 and `length`=MAX_LEN: pending is cleared and there is no growth.
  - `eat_evt` without a tick adds to pending, which is a 4-bit counter saturating at 15.
- Self-collision: the next head equals any seg[i] for 1≤i≤`length`-1.
  - The tail slot is excluded on a non-growing tick, because the tail moves away.
  - On collision, positions stay unchanged and the state goes to DEAD.
- `head_x`/`head_y` are registered copies of seg0, updated in the same cycle as seg0. There is no one-tick lag.
- Segments at index ≥`length` hold the tail position. The renderer uses `length` to mask them.

## Timing
- Reset values:
  - State IDLE; `alive`=0, `game_over`=0, `step`=0.
  - `length`=INIT_LEN; head=(START_X, START_Y); buses hold the initial layout.
- A tick in RUN at cycle N updates seg*, `head_*` and `length` at edge N+1. `step`=1 during cycle N+1.
- On collision at tick N: `alive` falls and `game_over`=1 at N+1, for one cycle. `step` is not asserted.
- `start` in DEAD: the state is reinitialised at N+1 and `alive`=1 at N+1.
- `start` in RUN is ignored. `start` coincident with `tick` in IDLE starts the game; that tick is not a move.
- Reset is asynchronous. Assertion mid-move forces reset values immediately; the in-flight tick is lost.
- All outputs are registered. Combinational paths: next-head compute and a MAX_LEN-wide comparator, within one clk_pix cycle.

## Test plan
- Reset, then 3 ticks in IDLE:
  - Head stays (310,230), `length`=2, `alive`=0.
  - `start`, then 3 ticks with dir=3: head (340,230), seg1 (330,230), 3 `step` pulses.
- Reversal: moving RIGHT, dir=1 on a tick -> head x+10, direction stays RIGHT. Then dir=0 -> y-10.
- Growth with GROW_PER_FOOD=2:
  - `eat_evt` with a tick -> `length` 2→3. Next tick -> 4. Third tick -> stays 4.
  - The old tail position is retained each growing tick.
- Walls:
  - WRAP_MODE=0, head (620,y) with RIGHT tick -> `game_over` pulse, head unchanged, `alive`=0. Then `start` -> head (310,230), `length`=2, `alive`=1.
  - WRAP_MODE=1: same stimulus -> head (10,y), `alive` stays 1.
- Self-collision:
  - `length`=5, turn DOWN, LEFT, UP into the body -> `game_over` on the UP tick.
  - `length`=4 chasing its own tail in a 2x2 loop -> no death.
- Saturation and reset:
  - At `length`=MAX_LEN, `eat_evt` -> `length` unchanged and pending cleared.
  - `reset` pulsed between ticks mid-RUN -> all reset values immediately, state IDLE.

Source files
------------

// File: rtl/snake_core_multi.sv
// Snake motion core: shift-register body, wall/wrap, reversal rejection, self-collision, growth, IDLE/RUN/DEAD.
// Latency: a RUN tick at cycle N commits at edge N+1; no backpressure, tick/start/eat_evt are one-cycle pulses.
module snake_core_multi #(
    parameter int CELL          = 10,
    parameter int GRID_W        = 64,
    parameter int GRID_H        = 48,
    parameter int MAX_LEN       = 32,
    parameter int INIT_LEN      = 2,
    parameter int GROW_PER_FOOD = 1,
    parameter int WRAP_MODE     = 0,
    parameter int START_X       = 310,
    parameter int START_Y       = 230
) (
    input  logic                   clk_pix,
    input  logic                   reset,
    input  logic                   tick,
    input  logic                   start,
    input  logic [1:0]             dir,
    input  logic                   eat_evt,
    output logic [9:0]             head_x,
    output logic [8:0]             head_y,
    output logic [7:0]             length,
    output logic                   alive,
    output logic                   game_over,
    output logic                   step,
    output logic [MAX_LEN*10-1:0]  body_bus_x,
    output logic [MAX_LEN*9-1:0]   body_bus_y
);
    localparam int BX = CELL;
    localparam int BY = CELL;
    localparam int MX = (GRID_W - 2) * CELL;
    localparam int MY = (GRID_H - 2) * CELL;
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [1:0] D_UP = 2'd0, D_LEFT = 2'd1, D_DOWN = 2'd2, D_RIGHT = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;

    state_t      state_q, state_d;
    logic [9:0]  seg_x_q [MAX_LEN];
    logic [9:0]  seg_x_d [MAX_LEN];
    logic [8:0]  seg_y_q [MAX_LEN];
    logic [8:0]  seg_y_d [MAX_LEN];
    logic [7:0]  len_q, len_d;
    logic [1:0]  dir_q, dir_d;
    logic [3:0]  pend_q, pend_d;
    logic        go_q, go_d;
    logic        step_q, step_d;

    logic [1:0]  eff_dir;
    logic [9:0]  nx;
    logic [8:0]  ny;
    logic        wall, hit, grow, collide, move, dead_evt, restart;
    logic [4:0]  pend_eff;
    logic [7:0]  new_len;
    logic [IW-1:0] tidx;
    int          hx, hy;

    function automatic logic [9:0] init_x(input int i);
        int k;
        k = (i < INIT_LEN) ? i : INIT_LEN - 1;
        return 10'(START_X - k * CELL);
    endfunction

    function automatic logic [3:0] sat15(input logic [4:0] v);
        return (v > 5'd15) ? 4'd15 : v[3:0];
    endfunction

    always_comb begin
        eff_dir = (dir == (dir_q ^ 2'd2)) ? dir_q : dir;
        hx      = int'(seg_x_q[0]);
        hy      = int'(seg_y_q[0]);
        nx      = seg_x_q[0];
        ny      = seg_y_q[0];
        wall    = 1'b0;
        case (eff_dir)
            D_UP: begin
                if (hy - CELL < BY) begin
                    if (WRAP_MODE != 0) ny = 9'(MY);
                    else                wall = 1'b1;
                end else ny = 9'(hy - CELL);
            end
            D_LEFT: begin
                if (hx - CELL < BX) begin
                    if (WRAP_MODE != 0) nx = 10'(MX);
                    else                wall = 1'b1;
                end else nx = 10'(hx - CELL);
            end
            D_DOWN: begin
                if (hy + CELL > MY) begin
                    if (WRAP_MODE != 0) ny = 9'(BY);
                    else                wall = 1'b1;
                end else ny = 9'(hy + CELL);
            end
            D_RIGHT: begin
                if (hx + CELL > MX) begin
                    if (WRAP_MODE != 0) nx = 10'(BX);
                    else                wall = 1'b1;
                end else nx = 10'(hx + CELL);
            end
        endcase
    end

    always_comb begin
        pend_eff = {1'b0, pend_q} + (eat_evt ? 5'(GROW_PER_FOOD) : 5'd0);
        grow     = (pend_eff != 5'd0) && (len_q < 8'(MAX_LEN));
        new_len  = grow ? len_q + 8'd1 : len_q;
        tidx     = IW'(new_len - 8'd2);
        // The tail slot only counts as an obstacle when it stays put, i.e. on a growing tick.
        hit = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if (8'(i) < len_q && (grow || 8'(i) != len_q - 8'd1) &&
                seg_x_q[i] == nx && seg_y_q[i] == ny)
                hit = 1'b1;
        end
        collide  = wall | hit;
        move     = (state_q == S_RUN) && tick && !collide;
        dead_evt = (state_q == S_RUN) && tick && collide;
        restart  = (state_q == S_DEAD) && start;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)            state_d = S_RUN;
            S_RUN:   if (tick && collide)  state_d = S_DEAD;
            S_DEAD:  if (start)            state_d = S_RUN;
            default:                       state_d = S_IDLE;
        endcase
    end

    always_comb begin
        seg_x_d = seg_x_q;
        seg_y_d = seg_y_q;
        len_d   = len_q;
        dir_d   = dir_q;
        pend_d  = pend_q;
        step_d  = move;
        go_d    = dead_evt;
        if (restart) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_d[i] = init_x(i);
                seg_y_d[i] = 9'(START_Y);
            end
            len_d  = 8'(INIT_LEN);
            dir_d  = D_RIGHT;
            pend_d = 4'd0;
        end else if (move) begin
            seg_x_d[0] = nx;
            seg_y_d[0] = ny;
            // Slots at or beyond the new length all collapse onto the new tail.
            for (int i = 1; i < MAX_LEN; i++) begin
                seg_x_d[i] = (8'(i) < new_len) ? seg_x_q[i-1] : seg_x_q[tidx];
                seg_y_d[i] = (8'(i) < new_len) ? seg_y_q[i-1] : seg_y_q[tidx];
            end
            len_d  = new_len;
            dir_d  = eff_dir;
            pend_d = grow ? sat15(pend_eff - 5'd1) : 4'd0;
        end else if (state_q == S_RUN && !tick && eat_evt) begin
            pend_d = sat15(pend_eff);
        end
    end

    always_ff @(posedge clk_pix or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= init_x(i);
                seg_y_q[i] <= 9'(START_Y);
            end
            len_q  <= 8'(INIT_LEN);
            dir_q  <= D_RIGHT;
            pend_q <= 4'd0;
            go_q   <= 1'b0;
            step_q <= 1'b0;
        end else begin
            state_q <= state_d;
            seg_x_q <= seg_x_d;
            seg_y_q <= seg_y_d;
            len_q   <= len_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            go_q    <= go_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        alive = (state_q == S_RUN);
    end

    assign head_x    = seg_x_q[0];
    assign head_y    = seg_y_q[0];
    assign length    = len_q;
    assign game_over = go_q;
    assign step      = step_q;

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_bus
        assign body_bus_x[(MAX_LEN-1-g)*10 +: 10] = seg_x_q[g];
        assign body_bus_y[(MAX_LEN-1-g)*9  +: 9]  = seg_y_q[g];
    end
endmodule

// File: tb/tb_snake_core_multi.sv
// Bench for snake_core_multi: a wall-kill core and a wrap core share one stimulus stream.
module tb_snake_core_multi;
    localparam int M = 5;

    logic clk_pix, reset, tick, start, eat_evt;
    logic [1:0] dir;

    logic [9:0] head_x0, head_x1;
    logic [8:0] head_y0, head_y1;
    logic [7:0] length0, length1;
    logic alive0, alive1, go0, go1, step0, step1;
    logic [M*10-1:0] bx0, bx1;
    logic [M*9-1:0]  by0, by1;

    snake_core_multi #(.MAX_LEN(M), .GROW_PER_FOOD(2), .WRAP_MODE(0)) dut0 (
        .clk_pix(clk_pix), .reset(reset), .tick(tick), .start(start), .dir(dir), .eat_evt(eat_evt),
        .head_x(head_x0), .head_y(head_y0), .length(length0), .alive(alive0), .game_over(go0),
        .step(step0), .body_bus_x(bx0), .body_bus_y(by0));

    snake_core_multi #(.MAX_LEN(M), .GROW_PER_FOOD(2), .WRAP_MODE(1)) dut1 (
        .clk_pix(clk_pix), .reset(reset), .tick(tick), .start(start), .dir(dir), .eat_evt(eat_evt),
        .head_x(head_x1), .head_y(head_y1), .length(length1), .alive(alive1), .game_over(go1),
        .step(step1), .body_bus_x(bx1), .body_bus_y(by1));

    initial begin
        clk_pix = 1'b0;
        forever #5 clk_pix = ~clk_pix;
    end

    typedef struct {
        logic tk, st, eat;
        logic [1:0] d;
        int hx, hy, len;
        logic al, go, sp;
        int s1x, s1y, tx, ty;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[26];
    int n_vec = 0, n_cmp = 0, n_miss = 0;

    function automatic vec_t mk(input logic tk, st, eat, input logic [1:0] d,
                                input int hx, hy, len, input logic al, go, sp,
                                input int s1x, s1y, tx, ty);
        vec_t v;
        v.tk = tk; v.st = st; v.eat = eat; v.d = d;
        v.hx = hx; v.hy = hy; v.len = len; v.al = al; v.go = go; v.sp = sp;
        v.s1x = s1x; v.s1y = s1y; v.tx = tx; v.ty = ty;
        return v;
    endfunction

    function automatic int seg_x(input logic [M*10-1:0] bus, input int i);
        return int'(bus[(M-1-i)*10 +: 10]);
    endfunction

    function automatic int seg_y(input logic [M*9-1:0] bus, input int i);
        return int'(bus[(M-1-i)*9 +: 9]);
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag);
        vec_t e;
        int ti;
        if (sb.size() == 0) begin
            n_miss++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        n_vec++;
        ti = (e.len >= 1 && e.len <= M) ? e.len - 1 : 0;
        cmp({tag, " head_x"}, 32'(head_x0), 32'(e.hx));
        cmp({tag, " head_y"}, 32'(head_y0), 32'(e.hy));
        cmp({tag, " length"}, 32'(length0), 32'(e.len));
        cmp({tag, " alive"},  32'(alive0),  32'(e.al));
        cmp({tag, " game_over"}, 32'(go0),  32'(e.go));
        cmp({tag, " step"},   32'(step0),   32'(e.sp));
        cmp({tag, " seg1_x"}, 32'(seg_x(bx0, 1)), 32'(e.s1x));
        cmp({tag, " seg1_y"}, 32'(seg_y(by0, 1)), 32'(e.s1y));
        cmp({tag, " tail_x"}, 32'(seg_x(bx0, ti)), 32'(e.tx));
        cmp({tag, " tail_y"}, 32'(seg_y(by0, ti)), 32'(e.ty));
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk_pix);
        tick = v.tk; start = v.st; eat_evt = v.eat; dir = v.d;
        sb.push_back(v);
        @(posedge clk_pix);
        #1;
        tick = 1'b0; start = 1'b0; eat_evt = 1'b0;
        check_out(tag);
    endtask

    initial begin
        vec_t v;
        int tx;
        tick = 0; start = 0; eat_evt = 0; dir = 2'd3;
        reset = 1'b1;

        //         tk st eat d   hx   hy  len al go sp  s1x  s1y  tx   ty
        tbl[0]  = mk(1, 0, 0, 3, 310, 230, 2, 0, 0, 0, 300, 230, 300, 230);
        tbl[1]  = mk(1, 0, 0, 3, 310, 230, 2, 0, 0, 0, 300, 230, 300, 230);
        tbl[2]  = mk(1, 0, 0, 3, 310, 230, 2, 0, 0, 0, 300, 230, 300, 230);
        tbl[3]  = mk(0, 1, 0, 3, 310, 230, 2, 1, 0, 0, 300, 230, 300, 230);
        tbl[4]  = mk(1, 0, 0, 3, 320, 230, 2, 1, 0, 1, 310, 230, 310, 230);
        tbl[5]  = mk(0, 0, 0, 3, 320, 230, 2, 1, 0, 0, 310, 230, 310, 230);
        tbl[6]  = mk(1, 0, 0, 3, 330, 230, 2, 1, 0, 1, 320, 230, 320, 230);
        tbl[7]  = mk(1, 0, 0, 3, 340, 230, 2, 1, 0, 1, 330, 230, 330, 230);
        tbl[8]  = mk(1, 0, 0, 1, 350, 230, 2, 1, 0, 1, 340, 230, 340, 230);
        tbl[9]  = mk(1, 0, 0, 0, 350, 220, 2, 1, 0, 1, 350, 230, 350, 230);
        tbl[10] = mk(1, 0, 1, 3, 360, 220, 3, 1, 0, 1, 350, 220, 350, 230);
        tbl[11] = mk(1, 0, 0, 3, 370, 220, 4, 1, 0, 1, 360, 220, 350, 230);
        tbl[12] = mk(1, 0, 0, 3, 380, 220, 4, 1, 0, 1, 370, 220, 350, 220);
        tbl[13] = mk(1, 0, 1, 3, 390, 220, 5, 1, 0, 1, 380, 220, 350, 220);
        tbl[14] = mk(1, 0, 0, 2, 390, 230, 5, 1, 0, 1, 390, 220, 360, 220);
        tbl[15] = mk(1, 0, 1, 1, 380, 230, 5, 1, 0, 1, 390, 230, 370, 220);
        tbl[16] = mk(1, 0, 0, 0, 380, 230, 5, 0, 1, 0, 390, 230, 370, 220);
        tbl[17] = mk(0, 0, 0, 0, 380, 230, 5, 0, 0, 0, 390, 230, 370, 220);
        tbl[18] = mk(1, 0, 0, 0, 380, 230, 5, 0, 0, 0, 390, 230, 370, 220);
        tbl[19] = mk(0, 1, 0, 3, 310, 230, 2, 1, 0, 0, 300, 230, 300, 230);
        tbl[20] = mk(1, 0, 1, 3, 320, 230, 3, 1, 0, 1, 310, 230, 300, 230);
        tbl[21] = mk(1, 0, 0, 2, 320, 240, 4, 1, 0, 1, 320, 230, 300, 230);
        tbl[22] = mk(1, 0, 0, 1, 310, 240, 4, 1, 0, 1, 320, 240, 310, 230);
        tbl[23] = mk(1, 0, 0, 0, 310, 230, 4, 1, 0, 1, 310, 240, 320, 230);
        tbl[24] = mk(1, 0, 0, 3, 320, 230, 4, 1, 0, 1, 310, 230, 320, 240);
        tbl[25] = mk(1, 0, 0, 2, 320, 240, 4, 1, 0, 1, 320, 230, 310, 240);

        #3;
        sb.push_back(mk(0, 0, 0, 3, 310, 230, 2, 0, 0, 0, 300, 230, 300, 230));
        check_out("reset");
        @(negedge clk_pix);
        reset = 1'b0;

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Run right to the east border at x=620.
        for (int k = 1; k <= 30; k++) begin
            if (k == 1)      tx = 310;
            else if (k == 2) tx = 320;
            else             tx = 320 + 10 * (k - 3);
            v = mk(1, 0, 0, 3, 320 + 10 * k, 240, 4, 1, 0, 1, 310 + 10 * k, 240, tx,
                   (k == 1 || k == 2) ? 230 : 240);
            apply(v, $sformatf("east%0d", k));
        end

        apply(mk(1, 0, 0, 3, 620, 240, 4, 0, 1, 0, 610, 240, 590, 240), "wall_kill");
        cmp("wrap head_x", 32'(head_x1), 32'd10);
        cmp("wrap head_y", 32'(head_y1), 32'd240);
        cmp("wrap alive",  32'(alive1),  32'd1);
        cmp("wrap step",   32'(step1),   32'd1);
        cmp("wrap game_over", 32'(go1),  32'd0);

        apply(mk(0, 1, 0, 3, 310, 230, 2, 1, 0, 0, 300, 230, 300, 230), "restart");
        cmp("run_start head_x", 32'(head_x1), 32'd10);
        cmp("run_start alive",  32'(alive1),  32'd1);
        cmp("run_start step",   32'(step1),   32'd0);

        apply(mk(1, 0, 0, 3, 320, 230, 2, 1, 0, 1, 310, 230, 310, 230), "pre_reset");

        // Reset lands while a tick is held, before the edge that would commit it.
        @(negedge clk_pix);
        tick = 1'b1; dir = 2'd3;
        #2 reset = 1'b1;
        #1;
        cmp("async head_x", 32'(head_x0), 32'd310);
        cmp("async head_y", 32'(head_y0), 32'd230);
        cmp("async length", 32'(length0), 32'd2);
        cmp("async alive",  32'(alive0),  32'd0);
        cmp("async step",   32'(step0),   32'd0);
        cmp("async seg1_x", 32'(seg_x(bx0, 1)), 32'd300);
        cmp("async wrap head_x", 32'(head_x1), 32'd310);
        cmp("async wrap alive",  32'(alive1),  32'd0);
        @(posedge clk_pix);
        #1;
        cmp("held head_x", 32'(head_x0), 32'd310);
        @(negedge clk_pix);
        tick = 1'b0;
        reset = 1'b0;

        apply(mk(1, 0, 0, 3, 310, 230, 2, 0, 0, 0, 300, 230, 300, 230), "idle_after_reset");
        apply(mk(0, 1, 0, 3, 310, 230, 2, 1, 0, 0, 300, 230, 300, 230), "start_after_reset");
        apply(mk(1, 0, 0, 3, 320, 230, 2, 1, 0, 1, 310, 230, 310, 230), "move_after_reset");

        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
